fpu_mul_iter: RTL and testbench
===============================

# fpu_mul_iter

Parametrised, iterative IEEE-754 binary floating-point multiplier; next generation of the single-precision FPU multiply unit. Format width, multiplier throughput and rounding are configurable. Full special-case handling, all five RISC-V rounding modes and the complete exception flag set are produced. It sits in the FPU execute stage beside the adder and divider and uses the same start/done handshake.

## Interface
- EXP_W, default 8: exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, default 23: stored fraction width; significand is MAN_W+1 bits.
- BPC, default 4: multiplier bits retired per MUL cycle; N = ceil((MAN_W+1)/BPC).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- operA, operB  in  1+EXP_W+MAN_W  IEEE operands.
- frm  in  3  rounding mode, latched with operands.
- result  out  1+EXP_W+MAN_W  registered product; held until the next done.
- fflags  out  5  {NV,DZ,OF,UF,NX}; DZ is always 0; held with result.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result/fflags are valid from this cycle on.

## Operation
- States: IDLE, MUL, NORM, ROUND, DONE.
- IDLE: on start, latch operands and frm, unpack, classify. A special operand goes to DONE. Otherwise go to MUL with the counter = 0.
- Classification: exp==0 means zero; subnormal inputs are flushed to zero, keeping their sign. exp all-ones with frac==0 is Inf. exp all-ones with frac!=0 is NaN; it is an sNaN if the frac MSB is 0.
- Special results:
  - Any NaN gives the canonical qNaN {0, all-ones, 1, 0...}.
  - Inf*0 gives the canonical qNaN with NV set.
  - Any sNaN operand sets NV.
  - Inf*nonzero gives Inf, sign sA^sB.
  - 0*finite gives zero, sign sA^sB.
  - All other flags are 0.
- MUL: shift-add product over a 2*(MAN_W+1)-bit accumulator. Retire BPC multiplier bits per cycle; the multiplier is zero-padded to N*BPC bits. Run N cycles, then go to NORM.
- Exponent: eR = eA+eB-BIAS, signed, EXP_W+2 bits wide.
- NORM: if the product MSB is set, eR+1 and take the significand from the top bits; else take it one bit lower. guard = next lower bit; sticky = OR of all remaining bits.
- ROUND: rounding increment is selected by frm:
  - 000 RNE: g&(s|lsb).
  - 001 RTZ: 0.
  - 010 RDN: sign&(g|s).
  - 011 RUP: !sign&(g|s).
  - 100 RMM: g.
  - 101-111: treated as RNE.
- Rounding carry-out: significand becomes 1.0 and eR+1.
- NX = g|s.
- Overflow: if eR >= 2^EXP_W-1, set OF|NX. The result is Inf, except max finite for RTZ, for RDN with a positive sign, and for RUP with a negative sign.
- Underflow: if eR <= 0, the result is flushed to signed zero with UF|NX.
- DONE: done=1, result/fflags registers loaded; next state is IDLE.
- start while busy is ignored; there is no queuing.

## Timing
- Reset values: result=0, fflags=0, done=0, busy=0, state=IDLE, counter=0.
- Normal path: start is sampled at edge 0. MUL covers edges 1..N, NORM is edge N+1, ROUND is edge N+2, then DONE. done is high in cycle N+3, which is cycle 9 for defaults with N=6.
- Special path: edge 0 goes to DONE; done is high in cycle 1.
- Back-to-back: start may be asserted in the cycle after DONE (IDLE). Minimum issue interval is N+4 cycles.
- Reset mid-operation (rst low in any state): all outputs take reset values immediately; the in-flight operation is discarded. The first start after release behaves normally.
- Inputs only need to be stable at the start-sampling edge.

## Test plan
- Defaults, RNE, 0x40400000*0x40200000 -> 0x40F00000, fflags=0. done in cycle 9; busy high for cycles 1-9.
- 0x3F800001*0x3F800001:
  - RNE -> 0x3F800002, NX.
  - RTZ -> 0x3F800002, NX.
  - RUP -> 0x3F800003, NX.
- 0x7F000000*0x40000000:
  - RNE -> 0x7F800000, fflags=00101.
  - RTZ -> 0x7F7FFFFF, fflags=00101.
- Special cases, each with done in cycle 1:
  - 0x7F800000*0x00000000 -> 0x7FC00000, NV=10000.
  - 0x7F800001*0x3F800000 -> 0x7FC00000, NV.
  - 0xFF800000*0x40000000 -> 0xFF800000, fflags=0.
- Underflow:
  - 0x00800000*0x3F000000 -> 0x00000000, fflags=00011.
  - 0x80800000*0x3F000000 -> 0x80000000, fflags=00011.
- EXP_W=5, MAN_W=10 (N=3): 0x4200*0x4100 -> 0x4780, done in cycle 6.
- Handshake and reset:
  - start pulsed mid-MUL is ignored.
  - rst low during MUL gives done=0, busy=0, result=0.
  - After release, the next op completes with the correct value.

Source files
------------

// File: rtl/fpu_mul_iter.sv
// fpu_mul_iter: iterative IEEE-754 multiplier, shift-add over BPC bits per cycle, flush-to-zero subnormals
module fpu_mul_iter #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BPC   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   operA,
   input  logic [EXP_W+MAN_W:0]   operB,
   input  logic [2:0]             frm,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             fflags,
   output logic                   busy,
   output logic                   done
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SW   = MAN_W + 1;
   localparam int PW   = 2 * SW;
   localparam int N    = (SW + BPC - 1) / BPC;
   localparam int MW   = N * BPC;
   localparam int EW   = EXP_W + 2;
   localparam int CW   = $clog2(N + 1);
   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
   state_t state, state_nx;

   logic              sa, sb, za, zb, ia, ib, na, nb, sna, snb, inz, special, sp_nv;
   logic [EXP_W-1:0]  ea, eb;
   logic [MAN_W-1:0]  fa, fb;
   logic [W-1:0]      sp_res;
   logic [CW-1:0]     cnt;
   logic              sgn, g, s;
   logic [2:0]        rm;
   logic [EW-1:0]     e_r, e_f;
   logic [PW-1:0]     mc, prod, nprod;
   logic [MW-1:0]     mplier;
   logic [SW-1:0]     sig;
   logic [SW:0]       rsum;
   logic              inc, ovf, unf, to_max;
   logic [W-1:0]      rnd_res;

   assign {sa, ea, fa} = operA;
   assign {sb, eb, fb} = operB;
   assign za = ea == '0;
   assign zb = eb == '0;
   assign ia = &ea && fa == '0;
   assign ib = &eb && fb == '0;
   assign na = &ea && fa != '0;
   assign nb = &eb && fb != '0;
   assign sna = na && !fa[MAN_W-1];
   assign snb = nb && !fb[MAN_W-1];
   assign inz = (ia | ib) & (za | zb);
   assign special = za | zb | ia | ib | na | nb;
   assign sp_nv = sna | snb | inz;
   assign sp_res = (na | nb | inz) ? QNAN :
                   (ia | ib) ? {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                   {sa ^ sb, {(W-1){1'b0}}};

   // normalise so the leading one sits at the product MSB
   assign nprod = prod[PW-1] ? prod : prod << 1;

   always_comb begin
      inc = rm == 3'd1 ? 1'b0 :
            rm == 3'd2 ? sgn & (g | s) :
            rm == 3'd3 ? !sgn & (g | s) :
            rm == 3'd4 ? g :
            g & (s | sig[0]);
      rsum = {1'b0, sig} + {{SW{1'b0}}, inc};
      e_f = e_r + EW'(rsum[SW]);
      ovf = !e_f[EW-1] && e_f >= EW'(2**EXP_W - 1);
      unf = e_f[EW-1] || e_f == '0;
      to_max = rm == 3'd1 || (rm == 3'd2 && !sgn) || (rm == 3'd3 && sgn);
      rnd_res = ovf ? (to_max ? {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}} :
                                {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}}) :
                unf ? {sgn, {(W-1){1'b0}}} :
                {sgn, e_f[EXP_W-1:0], rsum[MAN_W-1:0]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  state_nx = start ? (special ? DONE : MUL) : IDLE;
         MUL:   state_nx = cnt == CW'(N-1) ? NORM : MUL;
         NORM:  state_nx = ROUND;
         ROUND: state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = state != IDLE;
   assign done = state == DONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         sgn <= 1'b0;
         rm <= '0;
         e_r <= '0;
         mc <= '0;
         mplier <= '0;
         prod <= '0;
         sig <= '0;
         g <= 1'b0;
         s <= 1'b0;
         result <= '0;
         fflags <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt <= '0;
               sgn <= sa ^ sb;
               rm <= frm;
               e_r <= EW'(ea) + EW'(eb) - EW'(BIAS);
               mc <= PW'({1'b1, fa});
               mplier <= MW'({1'b1, fb});
               prod <= '0;
               if (special) begin
                  result <= sp_res;
                  fflags <= {sp_nv, 4'b0000};
               end
            end
            MUL: begin
               prod <= prod + mc * PW'(mplier[BPC-1:0]);
               mc <= mc << BPC;
               mplier <= mplier >> BPC;
               cnt <= cnt + 1'b1;
            end
            NORM: begin
               sig <= nprod[PW-1 -: SW];
               g <= nprod[PW-1-SW];
               s <= |nprod[PW-2-SW:0];
               e_r <= e_r + EW'(prod[PW-1]);
            end
            ROUND: begin
               result <= rnd_res;
               fflags <= {2'b00, ovf, unf, g | s | ovf | unf};
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_mul_iter.sv
// tb_fpu_mul_iter: directed vectors for the default single-precision and a half-precision instance
module tb_fpu_mul_iter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, start2 = 1'b0;
   logic [31:0] opa = '0, opb = '0;
   logic [2:0]  frm = '0;
   logic [31:0] result;
   logic [15:0] result2;
   logic [4:0]  fflags, fflags2;
   logic        busy, done, busy2, done2;
   int          n_chk = 0, n_fail = 0;
   int          cyc, bcnt;

   always #5 clk = ~clk;

   fpu_mul_iter dut (
      .clk(clk), .rst(rst), .start(start), .operA(opa), .operB(opb), .frm(frm),
      .result(result), .fflags(fflags), .busy(busy), .done(done)
   );

   fpu_mul_iter #(.EXP_W(5), .MAN_W(10), .BPC(4)) dut_h (
      .clk(clk), .rst(rst), .start(start2), .operA(opa[15:0]), .operB(opb[15:0]), .frm(frm),
      .result(result2), .fflags(fflags2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(input bit sm, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] rm, input int poke, output int c, output int bc);
      @(posedge clk);
      @(negedge clk);
      opa = a; opb = b; frm = rm;
      if (sm) start2 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start2 = 1'b0;
      c = 1;
      bc = int'(sm ? busy2 : busy);
      while (!(sm ? done2 : done) && c < 40) begin
         if (c == poke) begin
            start = 1'b1; opa = 32'h3F800000; opb = 32'h40000000;
         end
         @(posedge clk); #1;
         start = 1'b0;
         c++;
         bc += int'(sm ? busy2 : busy);
      end
   endtask

   initial begin
      #1;
      chk("rst_result", result, 32'h0);
      chk("rst_fflags", {27'd0, fflags}, 32'h0);
      chk("rst_done", {31'd0, done}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run(0, 32'h40400000, 32'h40200000, 3'd0, -1, cyc, bcnt);
      chk("basic_res", result, 32'h40F00000);
      chk("basic_flags", {27'd0, fflags}, 32'h0);
      chk("basic_cycle", cyc, 9);
      chk("basic_busy", bcnt, 9);
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done}, 32'h0);

      run(0, 32'h3F800001, 32'h3F800001, 3'd0, -1, cyc, bcnt);
      chk("rne_res", result, 32'h3F800002);
      chk("rne_flags", {27'd0, fflags}, 32'h1);
      run(0, 32'h3F800001, 32'h3F800001, 3'd1, -1, cyc, bcnt);
      chk("rtz_res", result, 32'h3F800002);
      chk("rtz_flags", {27'd0, fflags}, 32'h1);
      run(0, 32'h3F800001, 32'h3F800001, 3'd3, -1, cyc, bcnt);
      chk("rup_res", result, 32'h3F800003);
      chk("rup_flags", {27'd0, fflags}, 32'h1);

      run(0, 32'h7F000000, 32'h40000000, 3'd0, -1, cyc, bcnt);
      chk("ovf_rne_res", result, 32'h7F800000);
      chk("ovf_rne_flags", {27'd0, fflags}, 32'h5);
      run(0, 32'h7F000000, 32'h40000000, 3'd1, -1, cyc, bcnt);
      chk("ovf_rtz_res", result, 32'h7F7FFFFF);
      chk("ovf_rtz_flags", {27'd0, fflags}, 32'h5);

      run(0, 32'h7F800000, 32'h00000000, 3'd0, -1, cyc, bcnt);
      chk("infzero_res", result, 32'h7FC00000);
      chk("infzero_flags", {27'd0, fflags}, 32'h10);
      chk("infzero_cycle", cyc, 1);
      run(0, 32'h7F800001, 32'h3F800000, 3'd0, -1, cyc, bcnt);
      chk("snan_res", result, 32'h7FC00000);
      chk("snan_flags", {27'd0, fflags}, 32'h10);
      chk("snan_cycle", cyc, 1);
      run(0, 32'hFF800000, 32'h40000000, 3'd0, -1, cyc, bcnt);
      chk("ninf_res", result, 32'hFF800000);
      chk("ninf_flags", {27'd0, fflags}, 32'h0);
      chk("ninf_cycle", cyc, 1);

      run(0, 32'h00800000, 32'h3F000000, 3'd0, -1, cyc, bcnt);
      chk("unf_pos_res", result, 32'h00000000);
      chk("unf_pos_flags", {27'd0, fflags}, 32'h3);
      run(0, 32'h80800000, 32'h3F000000, 3'd0, -1, cyc, bcnt);
      chk("unf_neg_res", result, 32'h80000000);
      chk("unf_neg_flags", {27'd0, fflags}, 32'h3);

      run(1, 32'h00004200, 32'h00004100, 3'd0, -1, cyc, bcnt);
      chk("half_res", {16'd0, result2}, 32'h4780);
      chk("half_flags", {27'd0, fflags2}, 32'h0);
      chk("half_cycle", cyc, 6);

      run(0, 32'h40400000, 32'h40200000, 3'd0, 3, cyc, bcnt);
      chk("poke_res", result, 32'h40F00000);
      chk("poke_cycle", cyc, 9);

      @(posedge clk);
      @(negedge clk);
      opa = 32'h40400000; opb = 32'h40200000; frm = 3'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_done", {31'd0, done}, 32'h0);
      chk("midrst_busy", {31'd0, busy}, 32'h0);
      chk("midrst_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      run(0, 32'h3F800001, 32'h3F800001, 3'd3, -1, cyc, bcnt);
      chk("post_rst_res", result, 32'h3F800003);
      chk("post_rst_cycle", cyc, 9);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
